// File: rtl/arm_pkg.sv
// Shared definitions for the ARM pipeline memory stage.
//   mem_state_t      : memory-stage FSM states
//   WAIT_CYCLES_DEF  : default SRAM access length in cycles (legal 1..15)
//   ADDR_BASE_DEF    : byte address mapped to SRAM word 0
//   CNT_W            : width of the wait-state counter
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  localparam int          WAIT_CYCLES_DEF = 5;
  localparam logic [31:0] ADDR_BASE_DEF   = 32'd1024;
  localparam int          CNT_W           = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Wait-state counter for SRAM accesses.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset, count -> 0
//   clr  : synchronous clear, count -> 0
//   en   : count up by one
//   last : high while count equals WAIT_CYCLES-1
module sram_wait_counter
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == LAST_VAL);

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the five-stage ARM pipeline. Performs one 32-bit access to
// an external single-port SRAM with a fixed number of wait states and stalls
// the upstream pipeline (ready = 0) while the access is in flight.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   MEM_R_EN, MEM_W_EN    : load / store request (both high -> store)
//   ALU_result            : byte address
//   Val_Rm                : store data
//   ready                 : 0 freezes the pipeline
//   mem_rdata             : last completed load data
//   sram_addr/wdata/we_n  : SRAM word address, write data, active-low write enable
//   sram_rdata            : SRAM read data
//
// state  | meaning
// IDLE   | waiting for a request; captures address/data/write flag when one is seen
// ACCESS | SRAM driven from captured registers for WAIT_CYCLES cycles
// DONE   | access finished, pipeline released for one cycle
module mem_stage
  import arm_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
  parameter int          ADDR_W      = 16,
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [31:0]       ALU_result,
  input  logic [31:0]       Val_Rm,
  output logic              ready,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we_n,
  input  logic [31:0]       sram_rdata
);

  mem_state_t        state;
  mem_state_t        state_next;
  logic              req;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_last;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              wr_q;

  assign req = MEM_R_EN | MEM_W_EN;

  // Addresses below the base wrap modulo 2^ADDR_W; byte offset is dropped.
  assign word_addr = ADDR_W'((ALU_result - ADDR_BASE) >> 2);

  sram_wait_counter #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_wait_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req) state_next = ACCESS;
      ACCESS:  if (cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready     = 1'b0;
    sram_we_n = 1'b1;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        ready   = ~req;
        cnt_clr = 1'b1;
      end
      ACCESS: begin
        sram_we_n = ~wr_q;
        cnt_en    = 1'b1;
      end
      DONE:    ready = 1'b1;
      default: ready = 1'b1;
    endcase
    if (rst) ready = 1'b1;
  end

  // Captured request drives the SRAM so upstream changes during ACCESS are harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      mem_rdata <= '0;
    end else begin
      if (state == IDLE && req) begin
        addr_q  <= word_addr;
        wdata_q <= Val_Rm;
        wr_q    <= MEM_W_EN;
      end
      if (state == ACCESS && cnt_last && !wr_q) begin
        mem_rdata <= sram_rdata;
      end
    end
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule
